pl_data_mem_resp: RTL and testbench
===================================

PL_DATA_MEM_RESP -- requirements
Module: pl_data_mem_resp

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with the clock port named clk and the reset port named clrn.
REQ-002 Parameter ADDR_W, default 6, SHALL set the word-index width (memory depth 2^ADDR_W words).
REQ-003 Parameter WAIT, default 2, SHALL set the wait-state count (legal range 0..15).
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-005 Port clrn, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port req, input, 1 bit, SHALL be the access request from the pipelined CPU MEM stage.
REQ-007 Port we, input, 1 bit, SHALL select write (1) or read (0).
REQ-008 Port addr, input, 32 bits, SHALL be the byte address.
REQ-009 Port datain, input, 32 bits, SHALL be the write data.
REQ-010 Port be, input, 4 bits, SHALL be the write byte enables; be[i] controls bits 8i+7:8i.
REQ-011 Port ready, output, 1 bit, SHALL be a one-cycle completion strobe.
REQ-012 Port dataout, output, 32 bits, SHALL be the registered read data.
REQ-013 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-014 Port err, output, 1 bit, SHALL flag a misaligned-access completion.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-016 In IDLE with req=1, the block SHALL capture addr, we, datain and be into internal registers at the clock edge (the accept edge); outside IDLE, req and all request inputs SHALL be ignored and SHALL NOT be queued.
REQ-017 On accept with addr[1:0]!=0, the block SHALL go directly to DONE, set err=1, and perform no memory access; dataout SHALL be unchanged.
REQ-018 On accept with addr[1:0]==0, the block SHALL load a 4-bit counter with WAIT and enter WAIT.
REQ-019 In WAIT with counter!=0, the counter SHALL decrement by 1 per cycle.
REQ-020 In WAIT with counter==0, the block SHALL perform the access at that edge and enter DONE.
REQ-021 The access SHALL use word index = captured addr[ADDR_W+1:2]; upper address bits SHALL be ignored (aliasing/wrap-around).
REQ-022 A write SHALL update only the bytes whose be bit is 1; dataout SHALL be unchanged on writes.
REQ-023 A read SHALL load the full word into dataout and ignore be.
REQ-024 ready SHALL be 1 exactly during the DONE cycle: WAIT+1 cycles after the accept edge for an aligned access, and the cycle immediately after the accept edge for a misaligned access.
REQ-025 err SHALL be 1 only while ready=1 for a misaligned access, and 0 otherwise.
REQ-026 DONE SHALL return to IDLE unconditionally on the next edge, so that back-to-back aligned requests complete once every WAIT+3 cycles.

Reset
REQ-027 When clrn=0, the block SHALL immediately force state=IDLE, ready=0, err=0, busy=0, dataout=0 and counter=0.
REQ-028 Memory contents SHALL NOT be altered by reset; a write not yet performed when clrn asserts SHALL be discarded, and its ready SHALL never pulse.
REQ-029 Memory contents after power-up are undefined; software and benches SHALL write a word before reading it.

Verification (WAIT=2, ADDR_W=6)
REQ-030 Write 0xDEADBEEF to address 0x10 with be=1111 -> ready=1 exactly 3 cycles after the accept edge, err=0; a subsequent read of 0x10 -> dataout=0xDEADBEEF with ready.
REQ-031 After REQ-030, write 0x11223344 to 0x10 with be=0101 -> a read of 0x10 returns 0xDE22BE44.
REQ-032 Request to address 0x13 -> ready=1 and err=1 in the cycle after the accept edge, busy high for 1 cycle, and word 0x10 unchanged.
REQ-033 Write 0xCAFEF00D to address 0x100 -> a read of address 0x000 returns 0xCAFEF00D (aliasing).
REQ-034 req held high continuously -> accepts occur only in IDLE, with exactly one ready pulse per 5 cycles and busy low for 1 cycle between operations.
REQ-035 Pulse clrn low during the WAIT phase of a write of 0x0 to 0x10 -> no ready pulse, all outputs 0, and a later read of 0x10 returns the prior contents.

Source files
------------

// File: rtl/pl_data_mem_resp.sv
// Data memory responder for a pipelined CPU MEM stage, with a configurable wait-state count.
// Latency: an aligned access completes WAIT+1 cycles after accept; a misaligned one completes on the next cycle.
// Backpressure: requests are taken only in IDLE; anything presented while busy is dropped, never queued.
module pl_data_mem_resp #(
  parameter int ADDR_W = 6,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] dataout,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx_q;
  logic                we_q;
  logic                mis_q;
  logic [31:0]         din_q;
  logic [3:0]          be_q;
  logic                accept;
  logic                do_access;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  // Upper address bits only alias onto the same words.
  logic                unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept    = (state == S_IDLE) && req;
  assign do_access = (state == S_WAIT) && (cnt == 4'd0);

  // Next-state logic: misaligned accesses skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (addr[1:0] != 2'b00) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, request capture on accept and wait-state countdown.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
      we_q  <= 1'b0;
      mis_q <= 1'b0;
      din_q <= 32'd0;
      be_q  <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q <= addr[ADDR_W+1:2];
        we_q  <= we;
        mis_q <= (addr[1:0] != 2'b00);
        din_q <= datain;
        be_q  <= be;
        if (addr[1:0] == 2'b00) begin
          cnt <= WAIT_CNT;
        end
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Byte-masked write into the array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= din_q[8*i +: 8];
        end
      end
    end
  end

  // Read data register, only updated by an aligned read.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dataout <= 32'd0;
    end else if (do_access && !we_q) begin
      dataout <= mem[idx_q];
    end
  end

  assign ready = (state == S_DONE);
  assign busy  = (state != S_IDLE);
  assign err   = (state == S_DONE) && mis_q;

endmodule

// File: tb/tb_pl_data_mem_resp.sv
// Self-checking bench for pl_data_mem_resp: directed cases plus randomized traffic against a word-array model.
// Latency: expects completion WAIT+1 edges after accept (aligned) or one edge after (misaligned).
// Backpressure: drives requests only when idle, except in the held-request test where busy-time inputs must be ignored.
module tb_pl_data_mem_resp;

  localparam int ADDR_W = 6;
  localparam int WAIT   = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        clrn;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] dataout;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [DEPTH];
  bit          valid     [DEPTH];
  logic [31:0] exp_dout;

  pl_data_mem_resp #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .datain  (datain),
    .be      (be),
    .ready   (ready),
    .dataout (dataout),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  // One request from idle; checks the whole completion window and the return to idle.
  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit mis;
    int lat;
    int idx;
    mis = (a[1:0] != 2'b00);
    lat = mis ? 1 : WAIT + 2;
    idx = int'(a[ADDR_W+1:2]);
    chk("pre_busy", {31'd0, busy}, 32'd0);
    req = 1'b1; we = w; addr = a; datain = d; be = b;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; datain = $urandom; be = $urandom;
      end
      chk("busy_during", {31'd0, busy}, 32'd1);
      if (k < lat) begin
        chk("ready_early", {31'd0, ready}, 32'd0);
      end else begin
        if (!mis) begin
          if (w) begin
            mem_model[idx] = merge(mem_model[idx], d, b);
            valid[idx] = 1'b1;
          end else begin
            exp_dout = mem_model[idx];
          end
        end
        chk("ready_done", {31'd0, ready}, 32'd1);
        chk("err_done", {31'd0, err}, {31'd0, mis});
        chk("dataout_done", dataout, exp_dout);
      end
    end
    @(negedge clk);
    chk("ready_after", {31'd0, ready}, 32'd0);
    chk("err_after", {31'd0, err}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  int          pulses;
  int          idle_cnt;
  int          last;
  logic [31:0] prior;
  logic [31:0] ra;
  int          ridx;
  logic        rw;
  logic [3:0]  rb;

  initial begin
    clrn = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; datain = 32'd0; be = 4'd0;
    exp_dout = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = 32'd0;
      valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dataout", dataout, 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Full write then read back.
    do_op(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    do_op(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("rd_deadbeef", dataout, 32'hDEADBEEF);

    // Partial byte-enable write.
    do_op(1'b1, 32'h10, 32'h11223344, 4'b0101);
    do_op(1'b0, 32'h10, 32'h0, 4'b1010);
    chk("rd_merge", dataout, 32'hDE22BE44);

    // Misaligned write must not touch memory.
    do_op(1'b1, 32'h13, 32'h55555555, 4'b1111);
    do_op(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("rd_after_mis", dataout, 32'hDE22BE44);

    // Aliasing of upper address bits.
    do_op(1'b1, 32'h100, 32'hCAFEF00D, 4'b1111);
    do_op(1'b0, 32'h000, 32'h0, 4'b0000);
    chk("rd_alias", dataout, 32'hCAFEF00D);

    // Request held high: only idle-cycle inputs (a read of 0x10) may be taken;
    // busy-time inputs are a write to the same word that must be ignored.
    pulses = 0; idle_cnt = 0; last = -1;
    for (int n = 0; n < 20; n++) begin
      req = 1'b1;
      if (!busy) begin
        we = 1'b0; addr = 32'h10; be = $urandom;
      end else begin
        we = 1'b1; addr = 32'h10; datain = $urandom; be = 4'hF;
      end
      @(negedge clk);
      if (ready) begin
        pulses++;
        chk("held_dout", dataout, mem_model[4]);
        chk("held_err", {31'd0, err}, 32'd0);
        if (last >= 0) chk("held_gap", n - last, 32'd5);
        last = n;
      end
      if (!busy) idle_cnt++;
    end
    req = 1'b0;
    exp_dout = mem_model[4];
    chk("held_pulses", pulses, 32'd4);
    chk("held_idle", idle_cnt, 32'd4);
    @(negedge clk);

    // Reset in the middle of a write's wait phase discards it.
    prior = mem_model[4];
    req = 1'b1; we = 1'b1; addr = 32'h10; datain = 32'h0; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_dout", dataout, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    exp_dout = 32'd0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("no_ready_after_rst", {31'd0, ready}, 32'd0);
    end
    do_op(1'b0, 32'h10, 32'h0, 4'b0000);
    chk("rd_prior", dataout, prior);

    // Randomized traffic over a few words with random aliasing and misalignment.
    for (int t = 0; t < 40; t++) begin
      ridx = $urandom_range(0, 7);
      ra = ($urandom & 32'hFFFF_FF00) | (ridx << 2);
      if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      rw = 1'($urandom_range(0, 1));
      rb = 4'($urandom_range(0, 15));
      if (ra[1:0] == 2'b00 && !valid[ridx]) begin
        rw = 1'b1;
        rb = 4'hF;
      end
      do_op(rw, ra, $urandom, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
